// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage. Issues loads/stores to a variable-latency
//               data memory (req/gnt/rvalid), stalls the front end while an
//               access is in flight and feeds MEM2WB. Optional stall counter
//               enabled by defining MEM_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [WORD_LEN-1:0]     alu_res_in,
    input  logic [WORD_LEN-1:0]     st_val_in,
    output logic                    wb_en,
    output logic                    mem_r_en,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic [WORD_LEN-1:0]     alu_res,
    output logic [WORD_LEN-1:0]     mem_read_val,
    output logic                    stall,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [WORD_LEN-1:0]     dmem_addr,
    output logic [WORD_LEN-1:0]     dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [WORD_LEN-1:0]     dmem_rdata,
    output logic [31:0]             stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_LEN-1:0] rdata_q;
    logic [WORD_LEN-1:0] rdata_next;
    logic                rst_hold;
    logic                access;
    logic                is_load;

    assign access  = mem_r_en_in | mem_w_en_in;
    // A combined read+write request is serviced as a load.
    assign is_load = mem_r_en_in;

    // rst_hold keeps every output quiet for one cycle after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rdata_q  <= '0;
            rst_hold <= 1'b1;
        end else begin
            state    <= state_next;
            rdata_q  <= rdata_next;
            rst_hold <= 1'b0;
        end
    end

    always_comb begin
        state_next   = state;
        rdata_next   = rdata_q;
        wb_en        = 1'b0;
        mem_r_en     = 1'b0;
        dest         = '0;
        alu_res      = '0;
        mem_read_val = '0;
        stall        = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;

        if (rst || rst_hold) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        stall      = 1'b1;
                        state_next = REQ;
                    end else begin
                        wb_en    = wb_en_in;
                        mem_r_en = mem_r_en_in;
                        dest     = dest_in;
                        alu_res  = alu_res_in;
                    end
                end
                REQ: begin
                    stall      = 1'b1;
                    dmem_req   = 1'b1;
                    dmem_we    = mem_w_en_in & ~mem_r_en_in;
                    dmem_addr  = alu_res_in;
                    dmem_wdata = st_val_in;
                    if (dmem_gnt) begin
                        if (!is_load) begin
                            state_next = DONE;
                        end else if (dmem_rvalid) begin
                            rdata_next = dmem_rdata;
                            state_next = DONE;
                        end else begin
                            state_next = WAIT;
                        end
                    end
                end
                WAIT: begin
                    stall = 1'b1;
                    if (dmem_rvalid) begin
                        rdata_next = dmem_rdata;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    wb_en        = wb_en_in;
                    mem_r_en     = mem_r_en_in;
                    dest         = dest_in;
                    alu_res      = alu_res_in;
                    mem_read_val = rdata_q;
                    state_next   = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed and randomized accesses checked
// against an access-level timing/data model.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_res_in, st_val_in;
    logic        wb_en, mem_r_en;
    logic [3:0]  dest;
    logic [31:0] alu_res, mem_read_val;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    mem_access_stage #(.WORD_LEN(32), .REG_ADDR_LEN(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .dest_in      (dest_in),
        .alu_res_in   (alu_res_in),
        .st_val_in    (st_val_in),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .dest         (dest),
        .alu_res      (alu_res),
        .mem_read_val (mem_read_val),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .stall_cycles (stall_cycles)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] model_rdata;   // last load data the stage should be holding
    int          model_stalls;  // stalled cycles since last reset

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic r, input logic w, input logic [3:0] d,
                         input logic [31:0] alu, input logic [31:0] st);
        wb_en_in    = wb;
        mem_r_en_in = r;
        mem_w_en_in = w;
        dest_in     = d;
        alu_res_in  = alu;
        st_val_in   = st;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counter(input string tag);
`ifdef MEM_STALL_CNT_EN
        check(tag, stall_cycles, 32'(model_stalls));
`else
        check(tag, stall_cycles, 32'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wb_en"},    32'(wb_en),    32'd0);
        check({tag, ".mem_r_en"}, 32'(mem_r_en), 32'd0);
        check({tag, ".dest"},     32'(dest),     32'd0);
        check({tag, ".alu_res"},  alu_res,       32'd0);
        check({tag, ".rd_val"},   mem_read_val,  32'd0);
        check({tag, ".stall"},    32'(stall),    32'd0);
        check({tag, ".req"},      32'(dmem_req), 32'd0);
        check({tag, ".we"},       32'(dmem_we),  32'd0);
        check({tag, ".addr"},     dmem_addr,     32'd0);
        check({tag, ".wdata"},    dmem_wdata,    32'd0);
        check({tag, ".cnt"},      stall_cycles,  32'd0);
    endtask

    // Non-memory instruction: zero added latency, optional stray rvalid.
    task automatic alu_op(input string tag, input logic wb, input logic [3:0] d,
                          input logic [31:0] alu, input logic stray);
        drive(wb, 1'b0, 1'b0, d, alu, $urandom);
        dmem_gnt    = 1'b0;
        dmem_rvalid = stray;
        dmem_rdata  = $urandom;
        @(negedge clk);
        check({tag, ".stall"},    32'(stall),    32'd0);
        check({tag, ".wb_en"},    32'(wb_en),    32'(wb));
        check({tag, ".mem_r_en"}, 32'(mem_r_en), 32'd0);
        check({tag, ".dest"},     32'(dest),     32'(d));
        check({tag, ".alu_res"},  alu_res,       alu);
        check({tag, ".rd_val"},   mem_read_val,  32'd0);
        check({tag, ".req"},      32'(dmem_req), 32'd0);
        next_cycle();
        dmem_rvalid = 1'b0;
    endtask

    // One load/store. gd = REQ cycles before gnt, rd = cycles from gnt to rvalid.
    // Timeline (cycle index c): 0 = IDLE, 1..1+gd = REQ, gnt at 1+gd,
    // rvalid at 1+gd+rd (loads), then the DONE cycle.
    task automatic mem_op(input string tag, input logic wb, input logic r, input logic w,
                          input logic [3:0] d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gd, input int rd);
        int gnt_c, rv_c, done_c;
        gnt_c  = 1 + gd;
        rv_c   = r ? gnt_c + rd : -1;
        done_c = r ? rv_c + 1 : gnt_c + 1;
        drive(wb, r, w, d, addr, wdata);
        for (int c = 0; c <= done_c; c++) begin
            dmem_gnt    = (c == gnt_c) ||
                          ((c == 0 || c > gnt_c) && ($urandom_range(0, 1) == 1));
            dmem_rvalid = (c == rv_c) ||
                          ((c == 0 || c == done_c) && ($urandom_range(0, 1) == 1));
            dmem_rdata  = (c == rv_c) ? rdata : $urandom;
            @(negedge clk);
            if (c < done_c) begin
                check({tag, ".stall"},    32'(stall),    32'd1);
                check({tag, ".bub_wb"},   32'(wb_en),    32'd0);
                check({tag, ".bub_mr"},   32'(mem_r_en), 32'd0);
                check({tag, ".req"},      32'(dmem_req), 32'((c >= 1) && (c <= gnt_c)));
                if (c >= 1 && c <= gnt_c) begin
                    check({tag, ".addr"},  dmem_addr,    addr);
                    check({tag, ".wdata"}, dmem_wdata,   wdata);
                    check({tag, ".we"},    32'(dmem_we), 32'(w & ~r));
                end else begin
                    check({tag, ".we_off"}, 32'(dmem_we), 32'd0);
                end
                model_stalls++;
            end else begin
                check({tag, ".d_stall"}, 32'(stall),    32'd0);
                check({tag, ".d_req"},   32'(dmem_req), 32'd0);
                check({tag, ".d_wb"},    32'(wb_en),    32'(wb));
                check({tag, ".d_mr"},    32'(mem_r_en), 32'(r));
                check({tag, ".d_dest"},  32'(dest),     32'(d));
                check({tag, ".d_alu"},   alu_res,       addr);
                check({tag, ".d_rval"},  mem_read_val,  model_rdata);
            end
            if (c == rv_c) model_rdata = rdata;
            next_cycle();
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check_counter({tag, ".cnt"});
    endtask

    initial begin
        rst = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        drive(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0);
        model_rdata = 32'h0; model_stalls = 0;

        // Outputs silent during reset and the cycle after release.
        @(negedge clk);
        check_all_zero("rst_on");
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_hold");
        next_cycle();

        alu_op("alu_basic", 1'b1, 4'd3, 32'h55, 1'b0);

        mem_op("ld_b2b_0", 1'b1, 1'b1, 1'b0, 4'd1, 32'h10, 32'h0, 32'h1111_0000, 0, 0);
        mem_op("ld_b2b_1", 1'b1, 1'b1, 1'b0, 4'd2, 32'h14, 32'h0, 32'h2222_0000, 0, 0);
        check_counter("two_loads_cnt");

        mem_op("ld_slow",  1'b1, 1'b1, 1'b0, 4'd5, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 2);
        mem_op("st_gnt3",  1'b0, 1'b0, 1'b1, 4'd0, 32'h40, 32'hCAFE, 32'h0, 3, 0);

        alu_op("stray_rv", 1'b1, 4'd7, 32'h1234, 1'b1);
        mem_op("st_after", 1'b0, 1'b0, 1'b1, 4'd0, 32'h44, 32'hBEEF, 32'h0, 0, 0);
        mem_op("ld_and_st", 1'b1, 1'b1, 1'b1, 4'd9, 32'h80, 32'h77, 32'hA5A5_5A5A, 1, 1);

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: alu_op("rnd_alu", 1'($urandom_range(0, 1)), 4'($urandom),
                          $urandom, 1'($urandom_range(0, 1)));
                1: mem_op("rnd_ld", 1'b1, 1'b1, 1'b0, 4'($urandom), $urandom, $urandom,
                          $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
                2: mem_op("rnd_st", 1'b0, 1'b0, 1'b1, 4'($urandom), $urandom, $urandom,
                          $urandom, $urandom_range(0, 3), 0);
                default: mem_op("rnd_rw", 1'b1, 1'b1, 1'b1, 4'($urandom), $urandom,
                          $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            endcase
        end

        // Reset arriving while the load waits for its data.
        drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h200, 32'h0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        check("rw.idle_stall", 32'(stall), 32'd1);
        next_cycle();
        dmem_gnt = 1'b1;
        @(negedge clk);
        check("rw.req", 32'(dmem_req), 32'd1);
        next_cycle();
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("rw.wait_stall", 32'(stall), 32'd1);
        check("rw.wait_req",   32'(dmem_req), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rw.rst_req",   32'(dmem_req), 32'd0);
        check("rw.rst_stall", 32'(stall),    32'd0);
        next_cycle();
        rst = 1'b0;
        model_rdata = 32'h0; model_stalls = 0;
        drive(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0);
        @(negedge clk);
        check_all_zero("rw.hold");
        next_cycle();
        alu_op("rw.alu", 1'b1, 4'd3, 32'h55, 1'b0);
        mem_op("rw.st", 1'b1, 1'b0, 1'b1, 4'd6, 32'h300, 32'h99, 32'h0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
